auto_corner_finder: RTL and testbench

- Scans the live video pixel stream for one full field and finds the four extreme marker pixels: top-left, top-right, bottom-right and bottom-left.
- Packs them into the 80-bit corner bus and issues a one-cycle set_corners strobe.
- Sits directly upstream of the manual corner-adjust stage, which loads the bus on the strobe; the user then trims the corners by hand.

---
 rtl/corner_pkg.sv | 19 +
 rtl/auto_corner_finder_if.sv | 18 +
 rtl/extreme_tracker.sv | 34 +++
 rtl/auto_corner_finder.sv | 78 +++++++
 tb/tb_auto_corner_finder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/corner_pkg.sv
// corner_pkg: shared widths, corner indices, bus slot offsets and FSM state codes
package corner_pkg;
    localparam int COORD_W = 10;
    localparam int BUS_W = 8 * COORD_W;
    localparam int METRIC_W = 11;
    localparam logic [METRIC_W-1:0] D_OFFSET = 11'd1024;
    localparam int TL = 0;
    localparam int TR = 1;
    localparam int BR = 2;
    localparam int BL = 3;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT_FIELD = 2'd1;
    localparam logic [1:0] SCAN = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;
    // c1x occupies the top slot, c4y the bottom one
    function automatic int slot_lsb(int corner, bit is_y);
        return BUS_W - COORD_W * (2 * corner + 1 + int'(is_y));
    endfunction
endpackage

// File: rtl/auto_corner_finder_if.sv
// auto_corner_finder_if: video pixel stream in, corner bus and status out
interface auto_corner_finder_if;
    import corner_pkg::*;
    logic field;
    logic pixel_valid;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic marker;
    logic arm;
    logic [BUS_W-1:0] auto_corners;
    logic set_corners;
    logic busy;
    logic fail;
    modport master(output field, pixel_valid, x, y, marker, arm,
                   input auto_corners, set_corners, busy, fail);
    modport slave(input field, pixel_valid, x, y, marker, arm,
                  output auto_corners, set_corners, busy, fail);
endinterface

// File: rtl/extreme_tracker.sv
// extreme_tracker: keeps the coordinates of the first pixel with the strictly best metric
module extreme_tracker
    import corner_pkg::*;
#(
    parameter bit MAXIMISE = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                init,
    input  logic                update,
    input  logic [METRIC_W-1:0] metric,
    input  logic [COORD_W-1:0]  x,
    input  logic [COORD_W-1:0]  y,
    output logic [COORD_W-1:0]  best_x,
    output logic [COORD_W-1:0]  best_y
);
    localparam logic [METRIC_W-1:0] START = MAXIMISE ? '0 : '1;
    logic [METRIC_W-1:0] best;
    logic better;
    assign better = MAXIMISE ? (metric > best) : (metric < best);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            best <= START;
            best_x <= '0;
            best_y <= '0;
        end else if (init) begin
            best <= START;
        end else if (update && better) begin
            best <= metric;
            best_x <= x;
            best_y <= y;
        end
    end
endmodule

// File: rtl/auto_corner_finder.sv
// auto_corner_finder: scans one armed field for the four extreme marker pixels and strobes them out
module auto_corner_finder
    import corner_pkg::*;
#(
    parameter int MIN_HITS = 16
) (
    input logic clk,
    input logic reset_n,
    auto_corner_finder_if.slave bus
);
    localparam int HW = $clog2(MIN_HITS + 1);
    localparam logic [HW-1:0] HIT_MAX = HW'(MIN_HITS);
    logic [1:0] state;
    logic field_q;
    logic [HW-1:0] hits;
    logic field_edge;
    logic init;
    logic scan_hit;
    logic [METRIC_W-1:0] s;
    logic [METRIC_W-1:0] d;
    logic [COORD_W-1:0] bx [4];
    logic [COORD_W-1:0] by [4];
    logic [BUS_W-1:0] corners_next;
    assign field_edge = bus.field & ~field_q;
    assign init = (state == WAIT_FIELD) && field_edge;
    // the pixel sharing a cycle with the closing field edge belongs to no scan
    assign scan_hit = (state == SCAN) && !field_edge && bus.pixel_valid && bus.marker;
    assign s = {1'b0, bus.x} + {1'b0, bus.y};
    assign d = {1'b0, bus.x} - {1'b0, bus.y} + D_OFFSET;
    assign bus.busy = (state == WAIT_FIELD) || (state == SCAN);
    for (genvar c = 0; c < 4; c++) begin : g_trk
        extreme_tracker #(.MAXIMISE(c == TR || c == BR)) u_trk (
            .clk(clk),
            .reset_n(reset_n),
            .init(init),
            .update(scan_hit),
            .metric((c == TL || c == BR) ? s : d),
            .x(bus.x),
            .y(bus.y),
            .best_x(bx[c]),
            .best_y(by[c])
        );
        assign corners_next[slot_lsb(c, 1'b0) +: COORD_W] = bx[c];
        assign corners_next[slot_lsb(c, 1'b1) +: COORD_W] = by[c];
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            field_q <= 1'b0;
            hits <= '0;
            bus.auto_corners <= '0;
            bus.set_corners <= 1'b0;
            bus.fail <= 1'b0;
        end else begin
            field_q <= bus.field;
            bus.set_corners <= 1'b0;
            if (state == IDLE && bus.arm) begin
                state <= WAIT_FIELD;
                bus.fail <= 1'b0;
            end else if (init) begin
                state <= SCAN;
                hits <= '0;
            end else if (state == SCAN && field_edge) begin
                state <= COMMIT;
                if (hits >= HIT_MAX) begin
                    bus.auto_corners <= corners_next;
                    bus.set_corners <= 1'b1;
                end else begin
                    bus.fail <= 1'b1;
                end
            end else if (state == COMMIT) begin
                state <= IDLE;
            end else if (scan_hit && hits < HIT_MAX) begin
                hits <= hits + HW'(1);
            end
        end
    end
endmodule

// File: tb/tb_auto_corner_finder.sv
// tb_auto_corner_finder: directed fields with a strobe scoreboard checking corners and timing
module tb_auto_corner_finder;
    import corner_pkg::*;
    typedef struct {
        logic [BUS_W-1:0] c;
        int at;
    } exp_t;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    auto_corner_finder_if bus();
    auto_corner_finder #(.MIN_HITS(16)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(string name, logic [BUS_W-1:0] got, logic [BUS_W-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h required=%h", name, got, want);
        end
    endtask
    function automatic logic [BUS_W-1:0] pack8(int a, int b, int c, int d, int e, int f, int g, int h);
        return {10'(a), 10'(b), 10'(c), 10'(d), 10'(e), 10'(f), 10'(g), 10'(h)};
    endfunction
    // strobes are matched against pushed expectations, including the cycle they appear in
    always @(negedge clk) begin
        if (bus.set_corners) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe got=%h required=no strobe", bus.auto_corners);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("corners", bus.auto_corners, e.c);
                check("strobe_cycle", BUS_W'(cyc), BUS_W'(e.at));
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pix(int px, int py, bit m = 1'b1, bit v = 1'b1);
        bus.pixel_valid = v;
        bus.x = 10'(px);
        bus.y = 10'(py);
        bus.marker = m;
        tick();
        bus.pixel_valid = 1'b0;
        bus.marker = 1'b0;
    endtask
    task automatic fill(int n, int px, int py);
        repeat (n) pix(px, py);
    endtask
    task automatic arm_pulse();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
    endtask
    task automatic field_pulse();
        bus.field = 1'b1;
        tick();
        bus.field = 1'b0;
        tick();
    endtask
    task automatic expect_commit(logic [BUS_W-1:0] c);
        q.push_back('{c: c, at: cyc + 1});
        field_pulse();
    endtask
    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.field = 0;
        bus.pixel_valid = 0;
        bus.x = 0;
        bus.y = 0;
        bus.marker = 0;
        bus.arm = 0;
        repeat (3) tick();
        check("rst_corners", bus.auto_corners, '0);
        check("rst_strobe", BUS_W'(bus.set_corners), '0);
        check("rst_busy", BUS_W'(bus.busy), '0);
        check("rst_fail", BUS_W'(bus.fail), '0);
        reset_n = 1'b1;
        tick();
        // basic four-corner field, with ignored invalid and non-marker pixels
        arm_pulse();
        check("wait_busy", BUS_W'(bus.busy), 1);
        field_pulse();
        pix(100, 50);
        pix(0, 0, 1'b1, 1'b0);
        pix(500, 60);
        pix(0, 0, 1'b0, 1'b1);
        pix(520, 400);
        pix(90, 410);
        fill(12, 300, 200);
        expect_commit(pack8(100, 50, 500, 60, 520, 400, 90, 410));
        check("ok_fail", BUS_W'(bus.fail), 0);
        check("ok_busy", BUS_W'(bus.busy), 0);
        // 15 hits: fail, corners retained
        arm_pulse();
        field_pulse();
        fill(15, 1, 1);
        field_pulse();
        tick();
        check("short_fail", BUS_W'(bus.fail), 1);
        check("short_keep", bus.auto_corners, pack8(100, 50, 500, 60, 520, 400, 90, 410));
        check("short_busy", BUS_W'(bus.busy), 0);
        // tie on s: the first pixel in raster order keeps TL
        arm_pulse();
        check("arm_clr_fail", BUS_W'(bus.fail), 0);
        check("arm_busy", BUS_W'(bus.busy), 1);
        field_pulse();
        pix(10, 20);
        pix(20, 10);
        fill(14, 300, 200);
        expect_commit(pack8(10, 20, 300, 200, 300, 200, 10, 20));
        // arm mid-scan and on the commit cycle are both ignored
        arm_pulse();
        field_pulse();
        fill(8, 400, 300);
        arm_pulse();
        fill(8, 400, 300);
        q.push_back('{c: pack8(400, 300, 400, 300, 400, 300, 400, 300), at: cyc + 1});
        bus.field = 1'b1;
        tick();
        bus.field = 1'b0;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        check("commit_arm_busy", BUS_W'(bus.busy), 0);
        repeat (3) tick();
        check("idle_busy", BUS_W'(bus.busy), 0);
        // reset mid-scan aborts immediately
        arm_pulse();
        field_pulse();
        fill(16, 1, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_busy", BUS_W'(bus.busy), 0);
        check("arst_corners", bus.auto_corners, '0);
        check("arst_strobe", BUS_W'(bus.set_corners), 0);
        tick();
        reset_n = 1'b1;
        field_pulse();
        check("post_rst_corners", bus.auto_corners, '0);
        // arm mid-field: pixels before the next edge are not scanned
        field_pulse();
        pix(0, 0);
        arm_pulse();
        pix(0, 0);
        pix(1023, 1023);
        pix(1023, 0);
        pix(0, 1023);
        check("midfield_busy", BUS_W'(bus.busy), 1);
        field_pulse();
        pix(200, 100);
        pix(600, 120);
        pix(610, 500);
        pix(190, 510);
        fill(12, 400, 300);
        expect_commit(pack8(200, 100, 600, 120, 610, 500, 190, 510));
        repeat (5) tick();
        check("queue_empty", BUS_W'(q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
